// File: rtl/vec_s8_writeback_if.sv
// ICB write-port bundle between the s8 writeback engine (master) and memory (slave).
interface vec_s8_writeback_if #(
    parameter int REG_WIDTH = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_read;
    logic [REG_WIDTH-1:0] cmd_addr;
    logic [31:0]          cmd_wdata;
    logic [3:0]           cmd_wmask;
    logic [1:0]           cmd_size;
    logic                 rsp_valid;
    logic                 rsp_ready;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_size, rsp_ready,
        input  cmd_ready, rsp_valid
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_size, rsp_ready,
        output cmd_ready, rsp_valid
    );
endinterface

// File: rtl/vec_s8_writeback.sv
// Writeback of 16-lane s8 vectors: a small vector FIFO feeds an FSM that packs each
// vector into little-endian 32-bit words and issues one ICB write per live word,
// row-strided per vector, with a tail-lane mask.
// Optional feature: define VEC_WB_PERF_CNT_EN to build the command-stall counter;
// otherwise stall_cycles is tied to zero.
module vec_s8_writeback #(
    parameter int VLEN       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int REG_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     init_cfg,
    input  logic [REG_WIDTH-1:0]     cfg_dst_base,
    input  logic [REG_WIDTH-1:0]     cfg_row_stride,
    input  logic [REG_WIDTH-1:0]     cfg_vec_count,
    input  logic [$clog2(VLEN):0]    cfg_valid_lanes,
    input  logic                     in_valid,
    input  logic [8*VLEN-1:0]        in_vec_s8,
    output logic                     in_ready,
    vec_s8_writeback_if.master       icb,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow_err,
    output logic [31:0]              stall_cycles
);
    localparam int NWORDS = VLEN / 4;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LANE_W = $clog2(VLEN) + 1;
    localparam logic [LANE_W-1:0] VLEN_L = LANE_W'(VLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [8*VLEN-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                       fifo_empty, fifo_full, push;
    logic [NWORDS-1:0][31:0]    head_words;

    logic [1:0]                 state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       ovf_q, ovf_d;
    logic [WIDX_W-1:0]          word_idx_q, word_idx_d;
    logic [REG_WIDTH-1:0]       vec_idx_q, vec_idx_d;
    logic [REG_WIDTH-1:0]       row_addr_q, row_addr_d;
    logic [REG_WIDTH-1:0]       stride_q, stride_d;
    logic [REG_WIDTH-1:0]       count_q, count_d;
    logic [LANE_W-1:0]          lanes_q, lanes_d;
    logic [WIDX_W-1:0]          last_word;
    logic                       cmd_valid;
    logic [REG_WIDTH-1:0]       word_off;
    logic [3:0]                 wmask_c;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push       = in_valid && !fifo_full;
    assign head_words = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign in_ready   = !fifo_full;

    // Every live word is a prefix of the vector, so words past the last live one are never visited.
    assign last_word  = WIDX_W'((int'(lanes_q) - 1) / 4);
    assign cmd_valid  = (state_q == S_CMD) && !fifo_empty;

    // Command fields, byte mask and word offset for the current word; zero when idle.
    always_comb begin
        word_off = '0;
        word_off[WIDX_W+1:2] = word_idx_q;
        for (int b = 0; b < 4; b++) begin
            wmask_c[b] = (int'(word_idx_q) * 4 + b) < int'(lanes_q);
        end
        icb.cmd_valid = cmd_valid;
        icb.cmd_read  = 1'b0;
        icb.cmd_size  = cmd_valid ? 2'b10 : 2'b00;
        icb.cmd_addr  = cmd_valid ? (row_addr_q + word_off) : '0;
        icb.cmd_wdata = cmd_valid ? head_words[word_idx_q] : '0;
        icb.cmd_wmask = cmd_valid ? wmask_c : 4'h0;
        icb.rsp_ready = (state_q == S_RSP);
    end

    assign busy         = busy_q;
    assign done         = (state_q == S_DONE);
    assign overflow_err = ovf_q;

    // Next-state logic for the FIFO pointers, transfer FSM and its address/index registers.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q || (in_valid && fifo_full);
        word_idx_d = word_idx_q;
        vec_idx_d  = vec_idx_q;
        row_addr_d = row_addr_q;
        stride_d   = stride_q;
        count_d    = count_q;
        lanes_d    = lanes_q;
        wr_ptr_d   = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (init_cfg) begin
                    row_addr_d = cfg_dst_base;
                    stride_d   = cfg_row_stride;
                    count_d    = cfg_vec_count;
                    lanes_d    = (cfg_valid_lanes == '0 || cfg_valid_lanes > VLEN_L) ?
                                 VLEN_L : cfg_valid_lanes;
                    word_idx_d = '0;
                    vec_idx_d  = '0;
                    busy_d     = 1'b1;
                    ovf_d      = in_valid && fifo_full;
                    state_d    = (cfg_vec_count == '0) ? S_DONE : S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_valid && icb.cmd_ready) state_d = S_RSP;
            end
            S_RSP: begin
                if (icb.rsp_valid) begin
                    if (word_idx_q != last_word) begin
                        word_idx_d = word_idx_q + WIDX_W'(1);
                        state_d    = S_CMD;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(1);
                        word_idx_d = '0;
                        vec_idx_d  = vec_idx_q + REG_WIDTH'(1);
                        row_addr_d = row_addr_q + stride_q;
                        state_d    = (vec_idx_q + REG_WIDTH'(1) == count_q) ? S_DONE : S_CMD;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            word_idx_q <= '0;
            vec_idx_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            word_idx_q <= word_idx_d;
            vec_idx_q  <= vec_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Tile configuration and running row address; only meaningful once a cfg is accepted.
    always_ff @(posedge clk) begin
        row_addr_q <= row_addr_d;
        stride_q   <= stride_d;
        count_q    <= count_d;
        lanes_q    <= lanes_d;
    end

    // Vector storage; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= in_vec_s8;
    end

`ifdef VEC_WB_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles a command waits on a not-ready slave.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && init_cfg) stall_d = '0;
        else if (cmd_valid && !icb.cmd_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rstn) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_vec_s8_writeback.sv
// Directed bench for vec_s8_writeback: a behavioural ICB slave records every write,
// and each scenario compares recorded traffic and status pins with hand-computed values.
module tb_vec_s8_writeback;
    logic         clk = 1'b0;
    logic         rstn;
    logic         init_cfg;
    logic [31:0]  cfg_dst_base, cfg_row_stride, cfg_vec_count;
    logic [4:0]   cfg_valid_lanes;
    logic         in_valid;
    logic [127:0] in_vec_s8;
    logic         in_ready, busy, done, overflow_err;
    logic [31:0]  stall_cycles;

    vec_s8_writeback_if #(.REG_WIDTH(32)) icb ();

    vec_s8_writeback #(.VLEN(16), .FIFO_DEPTH(4), .REG_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .init_cfg(init_cfg),
        .cfg_dst_base(cfg_dst_base), .cfg_row_stride(cfg_row_stride),
        .cfg_vec_count(cfg_vec_count), .cfg_valid_lanes(cfg_valid_lanes),
        .in_valid(in_valid), .in_vec_s8(in_vec_s8), .in_ready(in_ready),
        .icb(icb.master), .busy(busy), .done(done),
        .overflow_err(overflow_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_mask[$];
    int          rsp_dly = 0;
    int          rdy_low_n = 0;
    int          stall_given = 0;
    int          stable_err = 0;
    int          done_cnt = 0;
    int          pend = 0;
    int          pend_cnt = 0;
    logic        stall_seen = 1'b0;
    logic [31:0] stall_addr, stall_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ICB slave: decides ready/response for the next edge and logs accepted writes.
    always @(negedge clk) begin
        if (!rstn) begin
            icb.cmd_ready = 1'b0;
            icb.rsp_valid = 1'b0;
            pend = 0;
            stall_seen = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (icb.rsp_valid) icb.rsp_valid = 1'b0;
            if (icb.cmd_valid && stall_given < rdy_low_n) begin
                if (!stall_seen) begin
                    stall_addr = icb.cmd_addr;
                    stall_data = icb.cmd_wdata;
                    stall_seen = 1'b1;
                end else if (icb.cmd_addr != stall_addr || icb.cmd_wdata != stall_data) begin
                    stable_err++;
                end
                stall_given++;
                icb.cmd_ready = 1'b0;
            end else begin
                icb.cmd_ready = 1'b1;
            end
            if (icb.cmd_valid && icb.cmd_ready) begin
                if (stall_seen && (icb.cmd_addr != stall_addr || icb.cmd_wdata != stall_data))
                    stable_err++;
                stall_seen = 1'b0;
                wr_addr.push_back(icb.cmd_addr);
                wr_data.push_back(icb.cmd_wdata);
                wr_mask.push_back(icb.cmd_wmask);
                pend = 1;
                pend_cnt = rsp_dly;
            end else if (pend != 0) begin
                if (pend_cnt == 0) begin
                    if (icb.rsp_ready) begin
                        icb.rsp_valid = 1'b1;
                        pend = 0;
                    end
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    function automatic logic [127:0] mkvec(input int start);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(start + i);
        return v;
    endfunction

    task automatic do_cfg(input logic [31:0] base, input logic [31:0] stride,
                          input logic [31:0] count, input int lanes);
        cfg_dst_base    = base;
        cfg_row_stride  = stride;
        cfg_vec_count   = count;
        cfg_valid_lanes = 5'(lanes);
        init_cfg        = 1'b1;
        @(negedge clk);
        init_cfg        = 1'b0;
    endtask

    task automatic push_vec(input logic [127:0] v);
        in_vec_s8 = v;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, done, 1'b1);
        @(negedge clk);
        check_val({tag, "_once"}, done, 1'b0);
    endtask

    initial begin
        logic [31:0] a1 [8];
        logic [31:0] d4 [4];
        int base_i;
        int stall_exp;

        a1 = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1040, 32'h1044, 32'h1048, 32'h104C};
        d4 = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
        rstn = 1'b0; init_cfg = 1'b0; in_valid = 1'b0; in_vec_s8 = '0;
        cfg_dst_base = '0; cfg_row_stride = '0; cfg_vec_count = '0; cfg_valid_lanes = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_ovf", overflow_err, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_cmd_valid", icb.cmd_valid, 1'b0);
        check_val("rst_stall", stall_cycles, 32'd0);

        // 1: two full vectors, always-ready slave
        base_i = wr_addr.size();
        do_cfg(32'h1000, 32'h40, 32'd2, 16);
        check_val("t1_busy", busy, 1'b1);
        push_vec(mkvec(0));
        push_vec(mkvec(16));
        wait_done("t1_done", 200);
        check_val("t1_nwr", wr_addr.size() - base_i, 8);
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("t1_addr%0d", k), wr_addr[base_i + k], a1[k]);
            check_val($sformatf("t1_mask%0d", k), wr_mask[base_i + k], 4'hF);
        end
        check_val("t1_wdata0", wr_data[base_i], 32'h03020100);
        check_val("t1_wdata4", wr_data[base_i + 4], 32'h13121110);
        check_val("t1_wdata7", wr_data[base_i + 7], 32'h1F1E1D1C);
        check_val("t1_busy_end", busy, 1'b0);
        check_val("t1_stall", stall_cycles, 32'd0);

        // 2: five live lanes -> two words, tail mask, words 2/3 skipped
        base_i = wr_addr.size();
        do_cfg(32'h2000, 32'h40, 32'd1, 5);
        push_vec(mkvec(8'hF0));
        wait_done("t2_done", 100);
        check_val("t2_nwr", wr_addr.size() - base_i, 2);
        check_val("t2_addr0", wr_addr[base_i], 32'h2000);
        check_val("t2_addr1", wr_addr[base_i + 1], 32'h2004);
        check_val("t2_mask0", wr_mask[base_i], 4'hF);
        check_val("t2_mask1", wr_mask[base_i + 1], 4'b0001);
        check_val("t2_wdata0", wr_data[base_i], 32'hF3F2F1F0);
        check_val("t2_wdata1", wr_data[base_i + 1], 32'hF7F6F5F4);

        // 3: slave holds ready low for 7 cycles on the first word
        base_i = wr_addr.size();
        rdy_low_n = stall_given + 7;
        do_cfg(32'h3000, 32'h10, 32'd1, 16);
        push_vec(mkvec(0));
        wait_done("t3_done", 100);
        check_val("t3_nwr", wr_addr.size() - base_i, 4);
        check_val("t3_addr0", wr_addr[base_i], 32'h3000);
        check_val("t3_wdata0", wr_data[base_i], 32'h03020100);
        check_val("t3_stable", stable_err, 0);
`ifdef VEC_WB_PERF_CNT_EN
        stall_exp = 7;
`else
        stall_exp = 0;
`endif
        check_val("t3_stall", stall_cycles, 32'(stall_exp));

        // 4: slow responses, six back-to-back vectors into a 4-deep FIFO
        base_i = wr_addr.size();
        rsp_dly = 20;
        do_cfg(32'h4000, 32'h40, 32'd4, 4);
        for (int k = 0; k < 6; k++) begin
            in_vec_s8 = mkvec(16 * k);
            in_valid  = 1'b1;
            @(negedge clk);
            if (k == 3) check_val("t4_ready_after4", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        check_val("t4_in_ready", in_ready, 1'b0);
        check_val("t4_ovf", overflow_err, 1'b1);
        wait_done("t4_done", 600);
        check_val("t4_nwr", wr_addr.size() - base_i, 4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t4_addr%0d", k), wr_addr[base_i + k], 32'h4000 + 32'h40 * k);
            check_val($sformatf("t4_wdata%0d", k), wr_data[base_i + k], d4[k]);
            check_val($sformatf("t4_mask%0d", k), wr_mask[base_i + k], 4'hF);
        end
        check_val("t4_ovf_sticky", overflow_err, 1'b1);
        rsp_dly = 0;

        // 5: empty tile, then init_cfg while busy is ignored
        base_i = wr_addr.size();
        do_cfg(32'h5000, 32'h40, 32'd0, 16);
        check_val("t5_done_now", done, 1'b1);
        check_val("t5_ovf_clr", overflow_err, 1'b0);
        @(negedge clk);
        check_val("t5_done_once", done, 1'b0);
        check_val("t5_busy", busy, 1'b0);
        check_val("t5_nwr", wr_addr.size() - base_i, 0);
        do_cfg(32'h6000, 32'h40, 32'd1, 4);
        do_cfg(32'h7000, 32'h80, 32'd3, 16);
        check_val("t5_busy2", busy, 1'b1);
        push_vec(mkvec(8'h60));
        wait_done("t5b_done", 100);
        check_val("t5b_nwr", wr_addr.size() - base_i, 1);
        check_val("t5b_addr", wr_addr[base_i], 32'h6000);
        check_val("t5b_wdata", wr_data[base_i], 32'h63626160);

        // 6: reset while waiting for a response, then a clean tile
        base_i = wr_addr.size();
        rsp_dly = 20;
        do_cfg(32'h8000, 32'h40, 32'd1, 4);
        push_vec(mkvec(8'h40));
        for (int n = 0; n < 20 && wr_addr.size() == base_i; n++) @(negedge clk);
        check_val("t6_cmd_seen", wr_addr.size() - base_i, 1);
        repeat (2) @(negedge clk);
        check_val("t6_in_rsp", icb.rsp_ready, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check_val("t6_rst_busy", busy, 1'b0);
        check_val("t6_rst_cmd", icb.cmd_valid, 1'b0);
        check_val("t6_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        rsp_dly = 0;
        @(negedge clk);
        base_i = wr_addr.size();
        do_cfg(32'h9000, 32'h40, 32'd1, 4);
        @(negedge clk);
        check_val("t6_fifo_empty", icb.cmd_valid, 1'b0);
        push_vec(mkvec(8'h50));
        wait_done("t6_done", 100);
        check_val("t6_nwr", wr_addr.size() - base_i, 1);
        check_val("t6_addr", wr_addr[base_i], 32'h9000);
        check_val("t6_wdata", wr_data[base_i], 32'h53525150);

        check_val("done_total", done_cnt, 7);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
